// File: rtl/rsa_keygen_euclid_pkg.sv
// Shared definitions for the RSA key generator: FSM states, error codes and width helper.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_TEST   = 3'd2,
    ST_DIV    = 3'd3,
    ST_UPDATE = 3'd4,
    ST_FINISH = 3'd5,
    ST_ERR    = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  localparam logic [1:0] ERR_OK          = 2'd0;
  localparam logic [1:0] ERR_BAD_PQ      = 2'd1;
  localparam logic [1:0] ERR_E_RANGE     = 2'd2;
  localparam logic [1:0] ERR_NOT_COPRIME = 2'd3;

  // Modulus-side width is twice the prime width so that p*q always fits.
  function automatic int calc_n_w(input int p_w);
    return 2 * p_w;
  endfunction

endpackage

// File: rtl/rsa_keygen_euclid_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; quo/rem valid on the done pulse,
// which arrives W cycles after the cycle in which start is high.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_r;
  logic [W-1:0]  dvs_r;

  // One restoring step: shift in the next dividend bit, subtract if it fits. Returns {rem, quo}.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r, input logic [W-1:0] q,
                                               input logic [W-1:0] dv);
    logic [W:0] trial;
    logic [W:0] diff;
    trial = {r, q[W-1]};
    diff  = trial - {1'b0, dv};
    if (trial >= {1'b0, dv}) begin
      return {diff[W-1:0], q[W-2:0], 1'b1};
    end else begin
      return {trial[W-1:0], q[W-2:0], 1'b0};
    end
  endfunction

  // The first step runs on the start edge itself so the result lands exactly W cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo   <= '0;
      rem   <= '0;
      dvs_r <= '0;
      cnt_r <= '0;
      done  <= 1'b0;
    end else if (start) begin
      {rem, quo} <= div_step('0, dividend, divisor);
      dvs_r      <= divisor;
      cnt_r      <= CW'(W - 1);
      done       <= (W == 1);
    end else if (cnt_r != '0) begin
      {rem, quo} <= div_step(rem, quo, dvs_r);
      cnt_r      <= cnt_r - CW'(1);
      done       <= (cnt_r == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa_keygen_euclid.sv
// RSA key generator: n = p*q, phi = (p-1)*(q-1), d = e^-1 mod phi by iterative extended Euclid
// using a shared sequential divider, with start/busy/done handshake and error reporting.
module rsa_keygen_euclid
  import rsa_pkg::*;
#(
  parameter int P_W = 8,
  parameter int N_W = calc_n_w(P_W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [P_W-1:0] p,
  input  logic [P_W-1:0] q,
  input  logic [N_W-1:0] e,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [N_W-1:0] n,
  output logic [N_W-1:0] d
);

  localparam int TW = N_W + 2;

  state_t state_r, state_s;

  logic [P_W-1:0]       p_r, q_r;
  logic [N_W-1:0]       e_r, phi_r, r0_r, r1_r;
  logic signed [TW-1:0] t0_r, t1_r;
  logic [1:0]           pend_code_r;

  logic                 div_start_s, div_done_s;
  logic [N_W-1:0]       div_quo_s, div_rem_s;

  logic [N_W-1:0]       pm1_s, qm1_s, phi_s, n_s, d_norm_s;
  logic                 bad_pq_s, bad_e_s;
  logic signed [TW-1:0] t_prod_s, t1_next_s;

  assign pm1_s    = {{(N_W-P_W){1'b0}}, p_r} - N_W'(1);
  assign qm1_s    = {{(N_W-P_W){1'b0}}, q_r} - N_W'(1);
  assign phi_s    = N_W'(pm1_s * qm1_s);
  assign n_s      = {{(N_W-P_W){1'b0}}, p_r} * {{(N_W-P_W){1'b0}}, q_r};
  assign bad_pq_s = (p_r < P_W'(2)) || (q_r < P_W'(2));
  assign bad_e_s  = (e_r == '0) || (e_r >= phi_s);

  // |t| never exceeds phi, so truncating the full-width product to TW bits is exact.
  assign t_prod_s  = TW'($signed({{TW{1'b0}}, div_quo_s}) * $signed({{N_W{t1_r[TW-1]}}, t1_r}));
  assign t1_next_s = t0_r - t_prod_s;
  assign d_norm_s  = N_W'(t0_r[TW-1] ? (t0_r + $signed({2'b00, phi_r})) : t0_r);

  seq_divider #(.W(N_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .dividend (r0_r),
    .divisor  (r1_r),
    .quo      (div_quo_s),
    .rem      (div_rem_s),
    .done     (div_done_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic and divider launch.
  always_comb begin
    state_s     = state_r;
    div_start_s = 1'b0;
    case (state_r)
      ST_IDLE:   if (start) state_s = ST_SETUP; else state_s = ST_IDLE;
      ST_SETUP:  if (bad_pq_s || bad_e_s) state_s = ST_ERR; else state_s = ST_TEST;
      ST_TEST: begin
        if (r1_r == '0) begin
          state_s = ST_FINISH;
        end else begin
          div_start_s = 1'b1;
          state_s     = ST_DIV;
        end
      end
      ST_DIV:    if (div_done_s) state_s = ST_UPDATE; else state_s = ST_DIV;
      ST_UPDATE: state_s = ST_TEST;
      ST_FINISH: if (r0_r != N_W'(1)) state_s = ST_ERR; else state_s = ST_DONE;
      ST_ERR:    state_s = ST_DONE;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they line up with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_s != ST_IDLE);
      done <= (state_s == ST_DONE);
    end
  end

  // Operand latch, Euclid recurrence and result/error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r         <= '0;
      q_r         <= '0;
      e_r         <= '0;
      phi_r       <= '0;
      r0_r        <= '0;
      r1_r        <= '0;
      t0_r        <= '0;
      t1_r        <= '0;
      pend_code_r <= ERR_OK;
      n           <= '0;
      d           <= '0;
      err         <= 1'b0;
      err_code    <= ERR_OK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            p_r      <= p;
            q_r      <= q;
            e_r      <= e;
            err      <= 1'b0;
            err_code <= ERR_OK;
            d        <= '0;
          end
        end
        ST_SETUP: begin
          n           <= n_s;
          phi_r       <= phi_s;
          r0_r        <= phi_s;
          r1_r        <= e_r;
          t0_r        <= '0;
          t1_r        <= TW'(1);
          pend_code_r <= bad_pq_s ? ERR_BAD_PQ : ERR_E_RANGE;
        end
        ST_UPDATE: begin
          r0_r <= r1_r;
          r1_r <= div_rem_s;
          t0_r <= t1_r;
          t1_r <= t1_next_s;
        end
        ST_FINISH: begin
          if (r0_r != N_W'(1)) pend_code_r <= ERR_NOT_COPRIME;
          else                 d           <= d_norm_s;
        end
        ST_ERR: begin
          err      <= 1'b1;
          err_code <= pend_code_r;
          d        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_keygen_euclid.sv
// Self-checking bench for rsa_keygen_euclid: directed spec vectors plus randomized requests
// checked against an integer extended-Euclid reference model.
module tb_rsa_keygen_euclid;
  localparam int P_W = 8;
  localparam int N_W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [P_W-1:0] p = '0;
  logic [P_W-1:0] q = '0;
  logic [N_W-1:0] e = '0;
  logic           busy, done, err;
  logic [1:0]     err_code;
  logic [N_W-1:0] n, d;

  int n_cmp = 0;
  int n_fail = 0;

  rsa_keygen_euclid #(.P_W(P_W)) dut (
    .clk(clk), .rst(rst), .start(start), .p(p), .q(q), .e(e),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .n(n), .d(d)
  );

  always #5 clk = ~clk;

  // Reference: plain integer extended Euclid; lat counts cycles from accept to done, inclusive.
  task automatic model(input int pp, input int qq, input longint ee, output longint mn,
                       output longint md, output int mcode, output int mlat);
    longint phi, r0, r1, t0, t1, qo, tmp;
    int k;
    mn = pp * qq;
    phi = (pp - 1) * (qq - 1);
    md = 0;
    k = 0;
    if (pp < 2 || qq < 2) begin
      mcode = 1; mlat = 4;
    end else if (ee == 0 || ee >= phi) begin
      mcode = 2; mlat = 4;
    end else begin
      r0 = phi; r1 = ee; t0 = 0; t1 = 1;
      while (r1 != 0) begin
        qo = r0 / r1;
        tmp = r0 - qo * r1; r0 = r1; r1 = tmp;
        tmp = t0 - qo * t1; t0 = t1; t1 = tmp;
        k++;
      end
      if (r0 != 1) begin
        mcode = 3; mlat = k * (N_W + 2) + 6;
      end else begin
        mcode = 0; md = (t0 < 0) ? t0 + phi : t0; mlat = k * (N_W + 2) + 5;
      end
    end
  endtask

  // Issue one request (caller is away from the rising edge) and collect the result.
  task automatic run_req(input int pp, input int qq, input int ee, output logic [N_W-1:0] on,
                         output logic [N_W-1:0] od, output logic oerr, output logic [1:0] ocode,
                         output int olat, output int pulses, output bit busy_ok, output bit tmo);
    int cnt;
    p = P_W'(pp); q = P_W'(qq); e = N_W'(ee); start = 1'b1;
    cnt = 0; pulses = 0; busy_ok = 1'b1; tmo = 1'b1; olat = 0;
    on = '0; od = '0; oerr = 1'b0; ocode = 2'd0;
    while (cnt < 3000) begin
      @(posedge clk); cnt++; #1;
      if (cnt == 1) start = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        pulses++; tmo = 1'b0; olat = cnt + 1;
        on = n; od = d; oerr = err; ocode = err_code;
        break;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (busy) busy_ok = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 ||
        n !== '0 || d !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b err=%b code=%0d n=%0d d=%0d, required all 0",
               busy, done, err, err_code, n, d);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [N_W-1:0] on, od; logic oerr; logic [1:0] oc; int lat, pulses; bit bok, tmo;
    longint mn, md; int mc, ml;
    model(61, 53, 17, mn, md, mc, ml);
    run_req(61, 53, 17, on, od, oerr, oc, lat, pulses, bok, tmo);
    n_cmp++; if (tmo) begin n_fail++; $display("FAIL basic_timeout: no done, required done"); end
    n_cmp++; if (on !== 16'd3233 || on !== N_W'(mn)) begin n_fail++; $display("FAIL basic_n: got %0d required %0d", on, mn); end
    n_cmp++; if (od !== 16'd2753 || od !== N_W'(md)) begin n_fail++; $display("FAIL basic_d: got %0d required %0d", od, md); end
    n_cmp++; if (oerr !== 1'b0 || oc !== 2'd0) begin n_fail++; $display("FAIL basic_err: got err=%b code=%0d required 0/0", oerr, oc); end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d required 1", pulses); end
    n_cmp++; if (!bok) begin n_fail++; $display("FAIL basic_busy: busy profile wrong, required high until done then low"); end
    n_cmp++; if (lat != ml) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", lat, ml); end
  endtask

  task automatic test_errors;
    int vp[5] = '{11, 11, 11, 11, 1};
    int vq[5] = '{13, 13, 13, 13, 13};
    int ve[5] = '{7, 6, 0, 120, 7};
    logic [N_W-1:0] on, od; logic oerr; logic [1:0] oc; int lat, pulses; bit bok, tmo;
    longint mn, md; int mc, ml;
    for (int i = 0; i < 5; i++) begin
      model(vp[i], vq[i], ve[i], mn, md, mc, ml);
      run_req(vp[i], vq[i], ve[i], on, od, oerr, oc, lat, pulses, bok, tmo);
      n_cmp++;
      if (tmo || on !== N_W'(mn) || od !== N_W'(md) || oerr !== (mc != 0) || oc !== 2'(mc) ||
          pulses != 1 || lat != ml || !bok) begin
        n_fail++;
        $display("FAIL err_vec%0d(p=%0d q=%0d e=%0d): got n=%0d d=%0d err=%b code=%0d lat=%0d pulses=%0d, required n=%0d d=%0d code=%0d lat=%0d pulses=1",
                 i, vp[i], vq[i], ve[i], on, od, oerr, oc, lat, pulses, mn, md, mc, ml);
      end
    end
  endtask

  task automatic test_latency;
    logic [N_W-1:0] on, od; logic oerr; logic [1:0] oc; int lat, pulses; bit bok, tmo;
    longint mn, md; int mc, ml;
    model(251, 241, 7, mn, md, mc, ml);
    run_req(251, 241, 7, on, od, oerr, oc, lat, pulses, bok, tmo);
    n_cmp++; if (on !== 16'd60491 || od !== 16'd17143) begin n_fail++; $display("FAIL big_nd: got n=%0d d=%0d required 60491/17143", on, od); end
    n_cmp++; if (tmo || lat != ml) begin n_fail++; $display("FAIL big_latency: got %0d required %0d", lat, ml); end
  endtask

  task automatic test_busy_ignore;
    logic [N_W-1:0] on, od; logic oerr; logic [1:0] oc; int lat, pulses, cnt; bit bok, tmo;
    p = 8'd61; q = 8'd53; e = 16'd17; start = 1'b1;
    @(posedge clk); #1;
    p = 8'd11; q = 8'd13; e = 16'd7;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    start = 1'b0;
    cnt = 0; pulses = 0;
    while (cnt < 3000 && !done) begin @(posedge clk); cnt++; #1; end
    if (done) pulses++;
    on = n; od = d;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done) pulses++; end
    n_cmp++; if (on !== 16'd3233 || od !== 16'd2753) begin n_fail++; $display("FAIL busy_ignore_result: got n=%0d d=%0d required 3233/2753", on, od); end
    n_cmp++; if (pulses != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_pulses: got %0d busy=%b required 1 and 0", pulses, busy); end
    @(negedge clk);
    run_req(61, 53, 1, on, od, oerr, oc, lat, pulses, bok, tmo);
    n_cmp++; if (tmo || od !== 16'd1 || oerr !== 1'b0) begin n_fail++; $display("FAIL e_one: got d=%0d err=%b required 1/0", od, oerr); end
  endtask

  task automatic test_reset_mid;
    logic [N_W-1:0] on, od; logic oerr; logic [1:0] oc; int lat, pulses; bit bok, tmo;
    longint mn, md; int mc, ml;
    p = 8'd61; q = 8'd53; e = 16'd17; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || n !== '0 || d !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b err=%b n=%0d d=%0d required all 0", busy, done, err, n, d);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (done) pulses++; end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done || busy) pulses++; end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL reset_mid_nodone: got %0d done/busy cycles required 0", pulses); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model(61, 53, 17, mn, md, mc, ml);
    run_req(61, 53, 17, on, od, oerr, oc, lat, pulses, bok, tmo);
    n_cmp++; if (tmo || od !== 16'd2753 || lat != ml) begin n_fail++; $display("FAIL after_reset: got d=%0d lat=%0d required 2753/%0d", od, lat, ml); end
  endtask

  task automatic test_random;
    logic [N_W-1:0] on, od; logic oerr; logic [1:0] oc; int lat, pulses; bit bok, tmo;
    longint mn, md; int mc, ml, pp, qq, ee, phi;
    for (int it = 0; it < 25; it++) begin
      pp = int'($urandom_range(0, 255));
      qq = int'($urandom_range(0, 255));
      phi = (pp - 1) * (qq - 1);
      if ($urandom_range(0, 3) != 0 && pp >= 2 && qq >= 2 && phi > 2)
        ee = int'($urandom_range(1, phi - 1));
      else
        ee = int'($urandom_range(0, 65535));
      model(pp, qq, ee, mn, md, mc, ml);
      run_req(pp, qq, ee, on, od, oerr, oc, lat, pulses, bok, tmo);
      n_cmp++;
      if (tmo || on !== N_W'(mn) || od !== N_W'(md) || oerr !== (mc != 0) || oc !== 2'(mc) ||
          lat != ml || pulses != 1 || !bok) begin
        n_fail++;
        $display("FAIL rand%0d(p=%0d q=%0d e=%0d): got n=%0d d=%0d err=%b code=%0d lat=%0d, required n=%0d d=%0d code=%0d lat=%0d",
                 it, pp, qq, ee, on, od, oerr, oc, lat, mn, md, mc, ml);
      end
      if (mc == 0) begin
        n_cmp++;
        if ((longint'(od) * ee) % phi != 1) begin
          n_fail++;
          $display("FAIL rand%0d_inverse: got d*e mod phi=%0d required 1", it, (longint'(od) * ee) % phi);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_errors;
    test_latency;
    test_busy_ignore;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
